// File: rtl/sorted_memory_writer.sv
// Collection end of the comparator-free sort: drives the engine's extract flag, captures
// one element per cycle into sorted memory (largest first) and flags bad index sequences.
module sorted_memory_writer #(
  parameter int ELEMENT_NUM      = 8,
  parameter int DATA_WIDTH       = 8,
  parameter int LOG2_ELEMENT_NUM = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ELEMENT_NUM*DATA_WIDTH-1:0] UM_data,
  input  logic [LOG2_ELEMENT_NUM-1:0]       LE_Addr,
  output logic                              flag,
  output logic                              sm_wr_en,
  output logic [LOG2_ELEMENT_NUM-1:0]       sm_wr_addr,
  output logic [DATA_WIDTH-1:0]             sm_wr_data,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                        state, state_nxt;
  logic [LOG2_ELEMENT_NUM-1:0]   cnt;
  logic [ELEMENT_NUM-1:0]        used;
  logic [DATA_WIDTH-1:0]         elem [ELEMENT_NUM];
  logic [DATA_WIDTH-1:0]         elem_sel;
  logic                          addr_ok;
  logic                          repeat_hit;
  logic                          last;

  for (genvar i = 0; i < ELEMENT_NUM; i++) begin : g_unpack
    assign elem[i] = UM_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Out-of-range indices only exist when ELEMENT_NUM is not a power of two.
  always_comb begin
    addr_ok    = (int'(LE_Addr) < ELEMENT_NUM);
    elem_sel   = addr_ok ? elem[LE_Addr] : '0;
    repeat_hit = addr_ok && used[LE_Addr];
    last       = (int'(cnt) == ELEMENT_NUM - 1);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SORT;
      SORT:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag       <= 1'b0;
      sm_wr_en   <= 1'b0;
      sm_wr_addr <= '0;
      sm_wr_data <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      used       <= '0;
    end else begin
      case (state)
        IDLE: begin
          sm_wr_en <= 1'b0;
          done     <= 1'b0;
          if (start) begin
            flag <= 1'b1;
            cnt  <= '0;
            used <= '0;
            err  <= 1'b0;
          end
        end
        SORT: begin
          sm_wr_en   <= 1'b1;
          sm_wr_addr <= cnt;
          sm_wr_data <= elem_sel;
          cnt        <= cnt + 1'b1;
          if (addr_ok)                err           <= err | repeat_hit;
          else                        err           <= 1'b1;
          if (addr_ok)                used[LE_Addr] <= 1'b1;
          // Final capture: the engine must stop extracting on the same edge.
          if (last) begin
            flag <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          sm_wr_en <= 1'b0;
          done     <= 1'b0;
        end
        default: begin
          sm_wr_en <= 1'b0;
          done     <= 1'b0;
          flag     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sorted_memory_writer.sv
// Directed bench for sorted_memory_writer with a behavioural sorting engine and a stub mode.
module tb_sorted_memory_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] um_data;
  logic [2:0]  le_addr;
  logic        flag, sm_wr_en, busy, done, err;
  logic [2:0]  sm_wr_addr;
  logic [7:0]  sm_wr_data;

  int checks   = 0;
  int failures = 0;

  logic       use_stub;
  logic [2:0] stub_addr;
  logic [2:0] stub_seq [8];
  logic [7:0] exp_data [8];
  logic       exp_err  [8];

  // Behavioural engine: largest remaining element, lowest index on ties.
  logic [7:0] evt = 8'hFF;
  logic [2:0] le_real;
  logic [7:0] best;
  logic       found;

  always #5 clk = ~clk;

  always_comb begin
    le_real = '0;
    best    = '0;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (evt[i] && (!found || um_data[i*8 +: 8] > best)) begin
        best    = um_data[i*8 +: 8];
        le_real = 3'(i);
        found   = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!flag) evt <= 8'hFF;
    else       evt[le_real] <= 1'b0;
  end

  assign le_addr = use_stub ? stub_addr : le_real;

  sorted_memory_writer #(
    .ELEMENT_NUM(8), .DATA_WIDTH(8), .LOG2_ELEMENT_NUM(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .UM_data(um_data), .LE_Addr(le_addr),
    .flag(flag), .sm_wr_en(sm_wr_en), .sm_wr_addr(sm_wr_addr), .sm_wr_data(sm_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_sort(input bit hold);
    check("idle_flag", 32'(flag), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_flag", 32'(flag), 32'd1);
    check("acc_wr",   32'(sm_wr_en), 32'd0);
    check("acc_err",  32'(err), 32'd0);
    for (int k = 0; k < 8; k++) begin
      stub_addr = stub_seq[k];
      @(posedge clk); #1;
      check("wr_en",   32'(sm_wr_en), 32'd1);
      check("wr_addr", 32'(sm_wr_addr), 32'(k));
      check("wr_data", 32'(sm_wr_data), 32'(exp_data[k]));
      check("done",    32'(done), (k == 7) ? 32'd1 : 32'd0);
      check("flag",    32'(flag), (k == 7) ? 32'd0 : 32'd1);
      check("busy",    32'(busy), 32'd1);
      check("err",     32'(err), 32'(exp_err[k]));
    end
    @(posedge clk); #1;
    check("end_wr",   32'(sm_wr_en), 32'd0);
    check("end_done", 32'(done), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_flag", 32'(flag), 32'd0);
    check("end_err",  32'(err), 32'(exp_err[7]));
  endtask

  task automatic set_test1;
    use_stub = 1'b0;
    um_data  = {8'd64, 8'd128, 8'd90, 8'd255, 8'd0, 8'd17, 8'd200, 8'd3};
    exp_data = '{8'd255, 8'd200, 8'd128, 8'd90, 8'd64, 8'd17, 8'd3, 8'd0};
    exp_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    use_stub  = 1'b0;
    stub_addr = '0;
    stub_seq  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    set_test1();
    repeat (3) @(posedge clk);
    #1;
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_wr",   32'(sm_wr_en), 32'd0);
    check("rst_addr", 32'(sm_wr_addr), 32'd0);
    check("rst_data", 32'(sm_wr_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: basic sort with the engine model
    run_sort(1'b0);

    // 2: start held high across two back-to-back sorts
    run_sort(1'b1);
    run_sort(1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    check("hold_off_busy", 32'(busy), 32'd0);

    // 3: asynchronous reset after the third write
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("pre_rst_addr", 32'(sm_wr_addr), 32'(k));
      check("pre_rst_data", 32'(sm_wr_data), 32'(exp_data[k]));
    end
    #2 rst = 1'b0;
    #1;
    check("arst_flag", 32'(flag), 32'd0);
    check("arst_wr",   32'(sm_wr_en), 32'd0);
    check("arst_addr", 32'(sm_wr_addr), 32'd0);
    check("arst_data", 32'(sm_wr_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_used", 32'(dut.used), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    run_sort(1'b0);

    // 4: stub repeats index 2
    use_stub = 1'b1;
    stub_seq = '{3'd2, 3'd2, 3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
    exp_data = '{8'd17, 8'd17, 8'd3, 8'd200, 8'd0, 8'd255, 8'd90, 8'd128};
    exp_err  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_sort(1'b0);
    @(posedge clk); #1;
    check("err_sticky_idle", 32'(err), 32'd1);

    // 6: swept stub indices; next start also clears err
    stub_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    exp_data = '{8'd64, 8'd128, 8'd90, 8'd255, 8'd0, 8'd17, 8'd200, 8'd3};
    exp_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_sort(1'b0);

    // 5: all-equal elements with the engine model
    use_stub = 1'b0;
    um_data  = {8{8'hAA}};
    exp_data = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    run_sort(1'b0);
    check("used_all", 32'(dut.used), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
